// File: rtl/uart_tx_sched.sv
// Frame sequencer between the UART TX FIFO read port and the bit-level transmitter.
// Optional feature macro UART_CTS_EN adds an active-low clear-to-send input that gates new frames.
module uart_tx_sched #(
  parameter int WIDTH     = 8,
  parameter int GAP_TICKS = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_r_data,
  input  logic             tx_busy,
  input  logic             tx_done,
  input  logic             baud_tick,
`ifdef UART_CTS_EN
  input  logic             cts_n,
`endif
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  output logic             sched_idle,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  // A 1-bit counter is kept even when no gap is configured so the design stays uniform.
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_cts_ok;
  logic             w_can_start;

`ifdef UART_CTS_EN
  assign w_cts_ok = ~cts_n;
`else
  assign w_cts_ok = 1'b1;
`endif

  assign w_can_start = enable & ~fifo_empty & ~tx_busy & w_cts_ok;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_can_start) w_next = S_POP;
      S_POP:   w_next = S_LATCH;
      S_LATCH: w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (tx_done) w_next = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (baud_tick && (r_gap_cnt == GAP_W'(1))) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO data is registered, so it is only valid in the cycle after the pop strobe (LATCH).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      tx_data   <= '0;
      frame_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LATCH) begin
        tx_data <= fifo_r_data;
      end
      if ((r_state == S_WAIT) && tx_done) begin
        frame_cnt <= frame_cnt + 1'b1;
        r_gap_cnt <= GAP_W'(GAP_TICKS);
      end else if ((r_state == S_GAP) && baud_tick) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  assign fifo_rd_en = (r_state == S_POP);
  assign tx_start   = (r_state == S_START);
  assign sched_idle = (r_state == S_IDLE);

endmodule
